bash_f_core: RTL

- Iterative controller and datapath for the full bash-f permutation (STB 34.101.77, 24 rounds).
- Registers the 1536-bit state and drives it through ROUNDS_PER_CYCLE chained copies of the existing round stage each clock.
- Sequences the 64-bit round constants into each stage.
- Sits between the sponge/hash front end (bash-hash, bash-prg) and the round stage; valid/ready on both sides.

---
 rtl/bash_f_pkg.sv | 69 ++++++
 rtl/bash_f_unroll.sv | 22 ++
 rtl/bash_f_core.sv | 116 +++++++++++
 3 files changed

// File: rtl/bash_f_pkg.sv
// Shared bash-f definitions: sizes, FSM states, round constants, S-box rotations
// and the single-round transform used by the unrolled chain.
package bash_f_pkg;

  localparam int BASH_STATE_W = 1536;
  localparam int BASH_WORD_W  = 64;
  localparam int BASH_ROUNDS  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bash_f_state_e;

  localparam logic [63:0] RC_BASH [0:23] = '{
    64'h3BF5080AC8BA94B1, 64'hC1D1659C1BBD92F6, 64'h60E8B2CE0DDEC97B, 64'hEC5FB8FE790FBC13,
    64'hAA043DE6436706A7, 64'h8929FF6A5E535BFD, 64'h98BF1E2C50C97550, 64'h4C5F8F162864BAA8,
    64'h262FC78B14325D54, 64'h1317E3C58A192EAA, 64'h098BF1E2C50C9755, 64'hD8EE19681D669304,
    64'h6C770CB40EB34982, 64'h363B865A0759A4C1, 64'hC73622B47C4C0ACE, 64'h639B115A3E260567,
    64'hEDE6693460F3DA1D, 64'hAAD8D5034F9935A0, 64'h556C6A81A7CC9AD0, 64'h2AB63540D3E64D68,
    64'h155B1AA069F326B4, 64'h0AAD8D5034F9935A, 64'h0556C6A81A7CC9AD, 64'hDE8082CD72DEBC78
  };

  // S-box rotation amounts for column j: (m1, n1, m2, n2)
  localparam int BASH_M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
  localparam int BASH_N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
  localparam int BASH_M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
  localparam int BASH_N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};
  localparam int BASH_PI [24] = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18,
                                  21, 20, 23, 22, 6, 3, 0, 7, 2, 5, 4, 1};

  function automatic logic [63:0] bash_rot(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // Out-of-range indices only occur while the chain output is ignored (DONE).
  function automatic logic [63:0] bash_rc_at(input logic [4:0] rnd, input int k);
    logic [5:0] idx;
    idx = {1'b0, rnd} + 6'(k);
    return (idx < 6'(BASH_ROUNDS)) ? RC_BASH[idx[4:0]] : '0;
  endfunction

  function automatic logic [BASH_STATE_W-1:0] bash_round(input logic [BASH_STATE_W-1:0] s_in,
                                                         input logic [63:0] c);
    logic [63:0] w [24];
    logic [63:0] o [24];
    logic [63:0] a, b, d, t1, t2;
    logic [BASH_STATE_W-1:0] s_out;
    for (int i = 0; i < 24; i++) w[i] = s_in[BASH_STATE_W-1-64*i -: 64];
    for (int j = 0; j < 8; j++) begin
      a  = w[j];
      b  = w[8+j];
      d  = w[16+j];
      t2 = bash_rot(a, BASH_M1[j]);
      a  = a ^ b ^ d;
      t1 = b ^ bash_rot(a, BASH_N1[j]);
      b  = t1 ^ t2;
      d  = d ^ bash_rot(d, BASH_M2[j]) ^ bash_rot(t1, BASH_N2[j]);
      w[j]    = a ^ (~d | b);
      w[8+j]  = b ^ (a | d);
      w[16+j] = d ^ (a & b);
    end
    for (int i = 0; i < 24; i++) o[i] = w[BASH_PI[i]];
    o[23] = o[23] ^ c;
    for (int i = 0; i < 24; i++) s_out[BASH_STATE_W-1-64*i -: 64] = o[i];
    return s_out;
  endfunction

endpackage

// File: rtl/bash_f_unroll.sv
// Purely combinational chain of RPC bash-f rounds; stage k uses constant rnd+k.
module bash_f_unroll
  import bash_f_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic [4:0]              i_rnd,
  input  logic [BASH_STATE_W-1:0] i_state,
  output logic [BASH_STATE_W-1:0] o_state
);

  logic [BASH_STATE_W-1:0] w_chain [0:RPC];

  assign w_chain[0] = i_state;

  for (genvar k = 0; k < RPC; k++) begin : g_stage
    assign w_chain[k+1] = bash_round(w_chain[k], bash_rc_at(i_rnd, k));
  end

  assign o_state = w_chain[RPC];

endmodule

// File: rtl/bash_f_core.sv
// Iterative bash-f permutation: state register, round counter and valid/ready
// sequencing around the unrolled round chain.
//
//   state | meaning
//   IDLE  | waiting for an input state, s_ready_o high
//   RUN   | applying ROUNDS_PER_CYCLE rounds per clock
//   DONE  | result presented on m_data_o until accepted
module bash_f_core
  import bash_f_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int N_ROUNDS         = BASH_ROUNDS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [BASH_STATE_W-1:0] s_data_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [BASH_STATE_W-1:0] m_data_o,
  output logic                    busy_o
);

  localparam bit RPC_OK = (ROUNDS_PER_CYCLE == 1) || (ROUNDS_PER_CYCLE == 2) ||
                          (ROUNDS_PER_CYCLE == 3) || (ROUNDS_PER_CYCLE == 4) ||
                          (ROUNDS_PER_CYCLE == 6) || (ROUNDS_PER_CYCLE == 8) ||
                          (ROUNDS_PER_CYCLE == 12) || (ROUNDS_PER_CYCLE == 24);

  if (!RPC_OK) begin : g_bad_rpc
    $error("bash_f_core: illegal ROUNDS_PER_CYCLE %0d", ROUNDS_PER_CYCLE);
  end
  if (N_ROUNDS != BASH_ROUNDS) begin : g_bad_rounds
    $error("bash_f_core: N_ROUNDS must be %0d", BASH_ROUNDS);
  end

  bash_f_state_e           r_fsm;
  logic [4:0]              r_rnd;
  logic                    r_m_valid;
  logic                    r_s_ready;
  logic                    r_busy;
  logic [BASH_STATE_W-1:0] r_state;
  logic [BASH_STATE_W-1:0] w_round_out;
  logic [5:0]              w_rnd_next;
  logic                    w_last;
  logic                    w_accept;

  bash_f_unroll #(
    .RPC (ROUNDS_PER_CYCLE)
  ) u_unroll (
    .i_rnd   (r_rnd),
    .i_state (r_state),
    .o_state (w_round_out)
  );

  assign w_rnd_next = {1'b0, r_rnd} + 6'(ROUNDS_PER_CYCLE);
  assign w_last     = (w_rnd_next == 6'(BASH_ROUNDS));
  assign w_accept   = (r_fsm == IDLE) && s_valid_i && r_s_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fsm     <= IDLE;
      r_rnd     <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_fsm     <= RUN;
            r_rnd     <= '0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        RUN: begin
          r_rnd <= w_rnd_next[4:0];
          if (w_last) begin
            r_fsm     <= DONE;
            r_m_valid <= 1'b1;
          end
        end
        DONE: begin
          if (r_m_valid && m_ready_i) begin
            r_fsm     <= IDLE;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_fsm     <= IDLE;
          r_rnd     <= '0;
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Datapath needs no reset: the output is masked until a result is valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (w_accept) r_state <= s_data_i;
      else if (r_fsm == RUN) r_state <= w_round_out;
    end
  end

  assign s_ready_o = r_s_ready;
  assign m_valid_o = r_m_valid;
  assign busy_o    = r_busy;
  assign m_data_o  = r_m_valid ? r_state : '0;

endmodule
